// File: rtl/msg_pkg.sv
// Shared constants, state encoding and address helper for the message scroller.
package msg_pkg;

  localparam int CHAR_W = 5;
  localparam int ADDR_W = 4;

  localparam logic [CHAR_W-1:0] CHAR_SPACE = 5'd27;
  localparam logic [ADDR_W-1:0] ADDR_FIRST = 4'd1;
  localparam logic [ADDR_W-1:0] ADDR_LAST  = 4'd15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    SHIFT = 2'd2,
    BLANK = 2'd3
  } scroll_state_t;

  // Address 0 is reserved, so the message walks 1..15 and wraps to 1.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == ADDR_LAST) ? ADDR_FIRST : a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/msg_tick.sv
// Step-rate prescaler: counts 0..CLK_DIV-1 while enabled and flags the last count.
module msg_tick #(
  parameter int CLK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] COUNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count;

  assign tick = en && (count == COUNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/msg_scroller.sv
// Scrolls the message ROM through a DIGITS-wide window at the prescaler rate.
// Optional blank tail between repeats: define MSG_SCROLL_BLANK_EN.
module msg_scroller
  import msg_pkg::*;
#(
  parameter int CLK_DIV = 50_000_000,
  parameter int DIGITS  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     restart,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [CHAR_W-1:0]        rom_data,
  output logic [DIGITS*CHAR_W-1:0] win,
  output logic                     win_valid,
  output logic                     wrap,
  output scroll_state_t            dbg_state
);

  localparam int SW = $clog2(DIGITS + 1);
  localparam logic [SW-1:0] SHIFT_FULL = SW'(DIGITS);

  // Handshake: none with the ROM (zero-latency read); the display takes win every
  // cycle and win_valid simply qualifies it once DIGITS characters have arrived.

  scroll_state_t state, state_nxt;
  logic [SW-1:0] shift_cnt;
  logic          tick;
  logic          presc_en;
  logic          do_shift;
  logic          do_blank;
  logic [CHAR_W-1:0]        shift_char;
  logic [DIGITS*CHAR_W-1:0] win_nxt;

  assign presc_en = en && ((state == WAIT) || (state == BLANK));

  msg_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (presc_en),
    .clear (restart),
    .tick  (tick)
  );

`ifdef MSG_SCROLL_BLANK_EN
  logic [SW-1:0] blank_cnt;
  assign do_blank = en && !restart && (state == BLANK) && tick;
`else
  assign do_blank = 1'b0;
`endif

  assign do_shift   = en && !restart && (state == SHIFT);
  assign shift_char = do_blank ? CHAR_SPACE : rom_data;
  assign win_valid  = (shift_cnt == SHIFT_FULL);
  assign dbg_state  = state;

  always_comb begin
    win_nxt = win;
    win_nxt[CHAR_W-1:0] = shift_char;
    for (int i = 1; i < DIGITS; i++) begin
      win_nxt[i*CHAR_W +: CHAR_W] = win[(i-1)*CHAR_W +: CHAR_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // restart outranks every other transition, including a pending SHIFT.
  always_comb begin
    state_nxt = state;
    if (restart) begin
      state_nxt = en ? WAIT : IDLE;
    end else if (en) begin
      case (state)
        IDLE:  state_nxt = WAIT;
        WAIT:  if (tick) state_nxt = SHIFT;
`ifdef MSG_SCROLL_BLANK_EN
        SHIFT: state_nxt = (rom_addr == ADDR_LAST) ? BLANK : WAIT;
        BLANK: if (tick && (blank_cnt == SW'(DIGITS - 1))) state_nxt = WAIT;
`else
        SHIFT: state_nxt = WAIT;
        BLANK: state_nxt = WAIT;
`endif
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr  <= ADDR_FIRST;
      win       <= {DIGITS{CHAR_SPACE}};
      shift_cnt <= '0;
      wrap      <= 1'b0;
    end else begin
      wrap <= do_shift && (rom_addr == ADDR_LAST);
      if (restart) begin
        rom_addr  <= ADDR_FIRST;
        win       <= {DIGITS{CHAR_SPACE}};
        shift_cnt <= '0;
      end else if (do_shift || do_blank) begin
        win <= win_nxt;
        if (shift_cnt != SHIFT_FULL) shift_cnt <= shift_cnt + SW'(1);
        if (do_shift) rom_addr <= next_addr(rom_addr);
      end
    end
  end

`ifdef MSG_SCROLL_BLANK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_cnt <= '0;
    end else if (restart || do_shift) begin
      blank_cnt <= '0;
    end else if (do_blank) begin
      blank_cnt <= blank_cnt + SW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_msg_scroller.sv
// Scoreboard bench for msg_scroller with CLK_DIV=4, DIGITS=4 and the LUBLINIEC 2025 ROM.
module tb_msg_scroller;
  import msg_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int DIGITS  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        restart = 1'b0;
  logic [3:0]  rom_addr;
  logic [4:0]  rom_data;
  logic [19:0] win;
  logic        win_valid;
  logic        wrap;
  scroll_state_t dbg_state;

  logic [4:0] rom [16];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int p0;
  logic mon_en = 1'b0;

  // Entry layout: {cycle[15:0], win[19:0], addr[3:0], valid}
  logic [40:0] exp_q[$];
  int          wrap_q[$];
  logic [40:0] e;
  int          wc;

  logic [19:0] m_win, prev_win;
  logic [3:0]  m_addr, prev_addr;
  int          m_cnt;

  msg_scroller #(.CLK_DIV(CLK_DIV), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .restart   (restart),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .win       (win),
    .win_valid (win_valid),
    .wrap      (wrap),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    rom = '{5'd31, 5'd19, 5'd24, 5'd11, 5'd19, 5'd1, 5'd20, 5'd1, 5'd14,
            5'd12, 5'd27, 5'd2, 5'd0, 5'd2, 5'd5, 5'd27};
  end
  assign rom_data = rom[rom_addr];

  initial begin
    #100000;
    $display("FAIL watchdog: cycle %0d reached time limit", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_ev(input int c);
    logic [15:0] c16;
    c16 = 16'(c);
    exp_q.push_back({c16, m_win, m_addr, (m_cnt >= DIGITS)});
  endtask

  task automatic exp_shift(input int c);
    m_win = {m_win[14:0], rom[m_addr]};
    if (m_addr == 4'd15) begin
      m_addr = 4'd1;
      wrap_q.push_back(c);
    end else begin
      m_addr = m_addr + 4'd1;
    end
    if (m_cnt < DIGITS) m_cnt++;
    push_ev(c);
  endtask

  // A blank shift into an all-space window is not observable, so nothing is queued.
  task automatic exp_blank(input int c);
    logic [19:0] old;
    old = m_win;
    m_win = {m_win[14:0], 5'd27};
    if (m_cnt < DIGITS) m_cnt++;
    if (m_win != old) push_ev(c);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // monitor: any visible change of win/rom_addr must match the next queued entry
  always @(negedge clk) begin
    if (mon_en && ((win !== prev_win) || (rom_addr !== prev_addr))) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_update", 32'(win), 32'(prev_win));
      end else begin
        e = exp_q.pop_front();
        chk("update_cycle", 32'(cyc), 32'(e[40:25]));
        chk("win", 32'(win), 32'(e[24:5]));
        chk("rom_addr", 32'(rom_addr), 32'(e[4:1]));
        chk("win_valid", 32'(win_valid), 32'(e[0]));
      end
    end
    if (mon_en && (wrap === 1'b1)) begin
      if (wrap_q.size() == 0) begin
        chk("unexpected_wrap", 32'(cyc), 32'(0));
      end else begin
        wc = wrap_q.pop_front();
        chk("wrap_cycle", 32'(cyc), 32'(wc));
      end
    end
    prev_win  = win;
    prev_addr = rom_addr;
  end

  initial begin
    m_win  = {4{5'd27}};
    m_addr = 4'd1;
    m_cnt  = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rom_addr", 32'(rom_addr), 32'(1));
    chk("reset_win", 32'(win), 32'(m_win));
    chk("reset_win_valid", 32'(win_valid), 32'(0));
    chk("reset_wrap", 32'(wrap), 32'(0));
    chk("reset_state", 32'(dbg_state), 32'(IDLE));
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    en = 1'b1;
    p0 = cyc + 1;
    for (int k = 1; k <= 15; k++) exp_shift(p0 + 5 * k);

`ifdef MSG_SCROLL_BLANK_EN
    exp_blank(p0 + 79);
    exp_blank(p0 + 83);
    exp_blank(p0 + 87);
    exp_blank(p0 + 91);
    exp_shift(p0 + 96);
    for (int k = 1; k <= 14; k++) exp_shift(p0 + 96 + 5 * k);
    exp_blank(p0 + 170);
    wait_cyc(p0 + 19);
    chk("valid_before_4th", 32'(win_valid), 32'(0));
    wait_cyc(p0 + 20);
    chk("win_after_4", 32'(win), 32'({5'd19, 5'd24, 5'd11, 5'd19}));
    chk("valid_after_4", 32'(win_valid), 32'(1));
    wait_cyc(p0 + 90);
    chk("blank_addr", 32'(rom_addr), 32'(1));
    chk("blank_win", 32'(win), 32'({4{5'd27}}));
    wait_cyc(p0 + 172);
    #1;
    rst_n  = 1'b0;
    m_win  = {4{5'd27}};
    m_addr = 4'd1;
    m_cnt  = 0;
    push_ev(p0 + 173);
    wait_cyc(p0 + 175);
    chk("midblank_reset_addr", 32'(rom_addr), 32'(1));
    chk("midblank_reset_win", 32'(win), 32'({4{5'd27}}));
    chk("midblank_reset_valid", 32'(win_valid), 32'(0));
    chk("midblank_reset_wrap", 32'(wrap), 32'(0));
    chk("midblank_reset_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
`else
    exp_shift(p0 + 80);
    wait_cyc(p0 + 19);
    chk("valid_before_4th", 32'(win_valid), 32'(0));
    wait_cyc(p0 + 20);
    chk("win_after_4", 32'(win), 32'({5'd19, 5'd24, 5'd11, 5'd19}));
    chk("valid_after_4", 32'(win_valid), 32'(1));
    // freeze with the prescaler at 2; the step then needs 2 more enabled edges
    wait_cyc(p0 + 82);
    en = 1'b0;
    wait_cyc(p0 + 92);
    chk("frozen_win", 32'(win), 32'(m_win));
    chk("frozen_addr", 32'(rom_addr), 32'(2));
    en = 1'b1;
    exp_shift(p0 + 95);
    // restart lands on the tick edge
    wait_cyc(p0 + 98);
    restart = 1'b1;
    m_win  = {4{5'd27}};
    m_addr = 4'd1;
    m_cnt  = 0;
    push_ev(p0 + 99);
    exp_shift(p0 + 104);
    wait_cyc(p0 + 99);
    restart = 1'b0;
    chk("restart_state", 32'(dbg_state), 32'(WAIT));
`endif

    for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    repeat (3) @(negedge clk);
    chk("pending_updates", 32'(exp_q.size()), 32'(0));
    chk("pending_wraps", 32'(wrap_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
